btb_array: RTL
==============

Name: btb_array

Overview:
- Storage and lookup stage for the branch target buffer: 4-way set-associative tag, target, valid and 2-bit predictor arrays, plus per-set pseudo-LRU state.
- Fetch port (fetch PC) produces the prediction.
- Writeback port (WB PC) produces the hit, way, current predictor and LRU victim consumed by the BTB update logic.
- Applies that logic's per-way write enables, predictor value and LRU touch on the clock edge.

Parameters:
- INDEX_BITS, 3: set index width; NUM_SETS = 2^INDEX_BITS. Index = pc[INDEX_BITS:1]. Tag = pc[15:INDEX_BITS+1], width 15-INDEX_BITS.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- fetch_pc  in  16  PC looked up at fetch
- hit  out  1  fetch_pc matches a valid way
- predict_taken  out  1  hit && pred[hit way][1]
- predicted_pc  out  16  target of the hit way; 0 when no hit
- wb_pc  in  16  PC of the branch in WB
- wb_target  in  16  resolved branch target to store
- wb_hit  out  1  wb_pc matches a valid way
- target_mux_sel  out  2  way index of the wb hit; 0 when no wb hit
- current_pred  out  2  predictor of the wb hit way; 0 when no wb hit
- lru  out  2  replacement victim way in the wb_pc set
- pred0_write..pred3_write  in  1 each  write pred_update into that way's predictor
- pred_update  in  2  new predictor value
- data0_write..data3_write  in  1 each  write wb_target into that way's target
- tag0_write..tag3_write  in  1 each  write wb_pc tag into that way; set valid
- LRU_write  in  1  touch the LRU for the written way

Behaviour:
- Both lookup ports are combinational on the current array contents. Writes occur on the rising edge of clk.
- No write-to-read bypass: in the cycle of a write, both ports return pre-write contents.
- Reset, asynchronous, active-high: all valid bits 0, predictors 2'b00, targets 0, tags 0, PLRU bits 0.
  - Outputs during and after reset: hit=0, predict_taken=0, predicted_pc=0, wb_hit=0, target_mux_sel=0, current_pred=0, lru=0.
  - Reset asserted mid-write discards the write.
- Hit: valid[set][w] && tag[set][w]==tag(pc).
  - If multiple ways match (must not occur), the lowest-numbered way wins.
- Writes are applied at set = index(wb_pc):
  - tagN_write: tag<=tag(wb_pc), valid<=1, pred<=pred_update. Install also seeds the predictor, whether or not predN_write is asserted.
  - dataN_write: target<=wb_target.
  - predN_write: pred<=pred_update.
  - Enables for different ways are independent.
- PLRU, 3 bits per set:
  - b0=0 victim in {0,1}, b0=1 victim in {2,3}.
  - b1 selects within {0,1} (0 selects way0); b2 selects within {2,3} (0 selects way2).
- lru output: lowest-numbered invalid way in the wb set if any; otherwise the PLRU victim.
- LRU_write touch, way w = lowest-numbered way with any tag/data/pred enable asserted:
  - w=0: b0<=1, b1<=1.
  - w=1: b0<=1, b1<=0.
  - w=2: b0<=0, b2<=1.
  - w=3: b0<=0, b2<=0.
  - LRU_write with no way enable: no change.
- Fetch lookups never modify state.
- The predictor encoding is a 2-bit saturating counter. Only bit1 drives predict_taken.

Test Plan:
- Reset, then fetch_pc=0x3000 and wb_pc=0x3000 -> hit=0, wb_hit=0, predict_taken=0, predicted_pc=0, lru=0.
- Install: wb_pc=0x3004, wb_target=0x3020, tag0/data0_write=1, LRU_write=1, pred_update=01; next cycle fetch_pc=0x3004 -> hit=1, predicted_pc=0x3020, predict_taken=0. wb_pc=0x3004 -> wb_hit=1, target_mux_sel=0, current_pred=01.
- Same-cycle read: fetch_pc equals the wb_pc being installed -> hit=0 in the write cycle, hit=1 the cycle after.
- Fill the set for index 2 with PCs 0x3004, 0x3014, 0x3024, 0x3034 into ways 0..3 in order -> lru reports 1, 2, 3 (invalid-first), then 0 once the set is full. Touch way 0 -> lru=2.
- pred1_write with pred_update=11 on a hit in way 1 -> current_pred=11 and predict_taken=1 next cycle; other ways' predictors unchanged.
- Assert reset asynchronously mid-cycle after installs -> all hits drop to 0 immediately. A write enabled at the following edge while reset is held is discarded.

Source files
------------

// File: rtl/btb_array_if.sv
// Port bundle for the BTB storage array: fetch lookup, writeback lookup and
// the per-way write controls driven by the BTB update logic.
interface btb_array_if;
  logic [15:0] fetch_pc;
  logic        hit;
  logic        predict_taken;
  logic [15:0] predicted_pc;

  logic [15:0] wb_pc;
  logic [15:0] wb_target;
  logic        wb_hit;
  logic [1:0]  target_mux_sel;
  logic [1:0]  current_pred;
  logic [1:0]  lru;

  logic        pred0_write, pred1_write, pred2_write, pred3_write;
  logic [1:0]  pred_update;
  logic        data0_write, data1_write, data2_write, data3_write;
  logic        tag0_write, tag1_write, tag2_write, tag3_write;
  logic        LRU_write;

  modport slave (
    input  fetch_pc, wb_pc, wb_target, pred_update, LRU_write,
    input  pred0_write, pred1_write, pred2_write, pred3_write,
    input  data0_write, data1_write, data2_write, data3_write,
    input  tag0_write, tag1_write, tag2_write, tag3_write,
    output hit, predict_taken, predicted_pc,
    output wb_hit, target_mux_sel, current_pred, lru
  );

  modport master (
    output fetch_pc, wb_pc, wb_target, pred_update, LRU_write,
    output pred0_write, pred1_write, pred2_write, pred3_write,
    output data0_write, data1_write, data2_write, data3_write,
    output tag0_write, tag1_write, tag2_write, tag3_write,
    input  hit, predict_taken, predicted_pc,
    input  wb_hit, target_mux_sel, current_pred, lru
  );
endinterface

// File: rtl/btb_array.sv
// 4-way set-associative BTB storage with tree pseudo-LRU per set.
// Both lookups read pre-write contents; writes land on the rising clock edge.
module btb_array #(
  parameter int INDEX_BITS = 3
) (
  input  logic        clk,
  input  logic        reset,
  btb_array_if.slave  bus
);
  localparam int NUM_SETS = 1 << INDEX_BITS;
  localparam int TAG_W    = 15 - INDEX_BITS;

  logic [TAG_W-1:0] r_tag   [NUM_SETS][4];
  logic [15:0]      r_tgt   [NUM_SETS][4];
  logic [1:0]       r_pred  [NUM_SETS][4];
  logic [3:0]       r_valid [NUM_SETS];
  logic [2:0]       r_plru  [NUM_SETS];

  logic [INDEX_BITS-1:0] w_f_idx, w_wb_idx;
  logic [TAG_W-1:0]      w_f_tag, w_wb_tag;
  logic [3:0]            w_f_match, w_wb_match;
  logic [1:0]            w_f_way, w_wb_way;
  logic [1:0]            w_invalid_way, w_plru_way;
  logic [3:0]            w_tag_we, w_data_we, w_pred_we, w_any_we;
  logic [1:0]            w_touch_way;
  logic [2:0]            w_cur_plru;
  logic                  w_unused;

  assign w_f_idx  = bus.fetch_pc[INDEX_BITS:1];
  assign w_f_tag  = bus.fetch_pc[15:INDEX_BITS+1];
  assign w_wb_idx = bus.wb_pc[INDEX_BITS:1];
  assign w_wb_tag = bus.wb_pc[15:INDEX_BITS+1];
  assign w_unused = ^{bus.fetch_pc[0], bus.wb_pc[0]};

  assign w_tag_we  = {bus.tag3_write,  bus.tag2_write,  bus.tag1_write,  bus.tag0_write};
  assign w_data_we = {bus.data3_write, bus.data2_write, bus.data1_write, bus.data0_write};
  assign w_pred_we = {bus.pred3_write, bus.pred2_write, bus.pred1_write, bus.pred0_write};
  assign w_any_we  = w_tag_we | w_data_we | w_pred_we;

  // Descending scans so the lowest-numbered matching way wins.
  always_comb begin
    w_f_match  = '0;
    w_wb_match = '0;
    w_f_way    = 2'd0;
    w_wb_way   = 2'd0;
    for (int w = 0; w < 4; w++) begin
      w_f_match[w]  = r_valid[w_f_idx][w]  && (r_tag[w_f_idx][w]  == w_f_tag);
      w_wb_match[w] = r_valid[w_wb_idx][w] && (r_tag[w_wb_idx][w] == w_wb_tag);
    end
    for (int w = 3; w >= 0; w--) begin
      if (w_f_match[w])  w_f_way  = 2'(w);
      if (w_wb_match[w]) w_wb_way = 2'(w);
    end
  end

  always_comb begin
    bus.hit            = |w_f_match;
    bus.predict_taken  = 1'b0;
    bus.predicted_pc   = 16'h0000;
    if (bus.hit) begin
      bus.predict_taken = r_pred[w_f_idx][w_f_way][1];
      bus.predicted_pc  = r_tgt[w_f_idx][w_f_way];
    end
    bus.wb_hit         = |w_wb_match;
    bus.target_mux_sel = 2'd0;
    bus.current_pred   = 2'b00;
    if (bus.wb_hit) begin
      bus.target_mux_sel = w_wb_way;
      bus.current_pred   = r_pred[w_wb_idx][w_wb_way];
    end
  end

  // Victim: lowest invalid way first, otherwise walk the PLRU tree.
  always_comb begin
    w_cur_plru    = r_plru[w_wb_idx];
    w_invalid_way = 2'd0;
    for (int w = 3; w >= 0; w--) begin
      if (!r_valid[w_wb_idx][w]) w_invalid_way = 2'(w);
    end
    if (w_cur_plru[0]) w_plru_way = w_cur_plru[2] ? 2'd3 : 2'd2;
    else               w_plru_way = w_cur_plru[1] ? 2'd1 : 2'd0;
    bus.lru = (&r_valid[w_wb_idx]) ? w_plru_way : w_invalid_way;
  end

  always_comb begin
    w_touch_way = 2'd0;
    for (int w = 3; w >= 0; w--) begin
      if (w_any_we[w]) w_touch_way = 2'(w);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= 4'b0000;
        r_plru[s]  <= 3'b000;
        for (int w = 0; w < 4; w++) begin
          r_tag[s][w]  <= '0;
          r_tgt[s][w]  <= 16'h0000;
          r_pred[s][w] <= 2'b00;
        end
      end
    end else begin
      for (int w = 0; w < 4; w++) begin
        // An install always seeds the predictor from pred_update.
        if (w_tag_we[w]) begin
          r_tag[w_wb_idx][w]   <= w_wb_tag;
          r_valid[w_wb_idx][w] <= 1'b1;
          r_pred[w_wb_idx][w]  <= bus.pred_update;
        end else if (w_pred_we[w]) begin
          r_pred[w_wb_idx][w]  <= bus.pred_update;
        end
        if (w_data_we[w]) r_tgt[w_wb_idx][w] <= bus.wb_target;
      end
      if (bus.LRU_write && (|w_any_we)) begin
        case (w_touch_way)
          2'd0: begin r_plru[w_wb_idx][0] <= 1'b1; r_plru[w_wb_idx][1] <= 1'b1; end
          2'd1: begin r_plru[w_wb_idx][0] <= 1'b1; r_plru[w_wb_idx][1] <= 1'b0; end
          2'd2: begin r_plru[w_wb_idx][0] <= 1'b0; r_plru[w_wb_idx][2] <= 1'b1; end
          default: begin r_plru[w_wb_idx][0] <= 1'b0; r_plru[w_wb_idx][2] <= 1'b0; end
        endcase
      end
    end
  end
endmodule
